pc_fetch_ctrl: RTL and testbench

- Consumer end of the next-PC path. Owns the architectural PC register, drives instruction-memory fetch requests, and delivers one fetched instruction at a time to decode.
- Generates sequential PC+4 internally.
- Accepts redirects (branch, jump, jr, exception vector, eret target) from execute/CP0.
- Sits between the imem port and the decode stage of the 54-instruction MIPS core.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/npc.sv | 19 +
 rtl/pc_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end.
// Holds the default reset PC, the instruction width and the fetch
// controller state encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam int          INSTR_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DELIVER = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/npc.sv
// Next-PC block: sequential increment of a PC.
// Ports:
//   rst     - forces the output to RESET_PC (tied 0 when used as a pure incrementer)
//   pc      - current PC
//   npc_pc  - pc + 4, modulo 2^ADDR_W (no overflow flag)
module npc
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc_pc
);

  assign npc_pc = rst ? RESET_PC : (pc + ADDR_W'(4));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: owns the architectural PC, issues instruction-memory
// requests and hands one fetched instruction at a time to decode.
// Ports:
//   clk, rst                  - core clock, async active-high reset
//   stall                     - decode cannot take the presented instruction
//   redirect_valid/_pc        - one-cycle flow change request and its target
//   imem_req/_addr            - fetch request (level) and word-aligned address
//   imem_ack/_rdata           - memory accept strobe and returned word
//   if_valid/_pc/_instr       - instruction presented to decode
//   if_pc_plus4               - link address for the presented instruction
//   addr_err                  - pulse, cycle after a misaligned redirect target
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               addr_err
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;

  // Low two bits are dropped silently; addr_err reports the misalignment.
  assign target = {redirect_pc[ADDR_W-1:2], 2'b00};

  npc #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_npc (
    .rst   (1'b0),
    .pc    (pc),
    .npc_pc(pc_plus4)
  );

  // pc is not touched while a request is outstanding, so it doubles as the
  // stable request address in both FETCH and FLUSH.
  assign imem_req  = (state == ST_FETCH) || (state == ST_FLUSH);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      pending_pc  <= '0;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
      addr_err    <= 1'b0;
    end else begin
      addr_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      case (state)
        ST_IDLE: begin
          if (redirect_valid) pc <= target;
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (redirect_valid) begin
            if (imem_ack) begin
              // Data for the old flow is dropped; refetch at once.
              pc <= target;
            end else begin
              // Request in flight must complete at the old address first.
              pending_pc <= target;
              state      <= ST_FLUSH;
            end
          end else if (imem_ack) begin
            if_pc       <= pc;
            if_instr    <= imem_rdata;
            if_pc_plus4 <= pc_plus4;
            if_valid    <= 1'b1;
            pc          <= pc_plus4;
            state       <= ST_DELIVER;
          end
        end
        ST_FLUSH: begin
          if (imem_ack) begin
            pc    <= redirect_valid ? target : pending_pc;
            state <= ST_FETCH;
          end else if (redirect_valid) begin
            pending_pc <= target;
          end
        end
        ST_DELIVER: begin
          if (redirect_valid) begin
            if_valid <= 1'b0;
            pc       <= target;
            state    <= ST_FETCH;
          end else if (!stall) begin
            if_valid <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_pc_plus4   (if_pc_plus4),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and advance into the first FETCH cycle.
  task automatic do_reset();
    stall = 0; redirect_valid = 0; redirect_pc = '0; imem_ack = 0; imem_rdata = '0;
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    stall = 0; redirect_valid = 0; imem_ack = 1; imem_rdata = 32'h1111_1111;
    #2 rst = 1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL rst_addr: got %h want 00400000", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_cmp++; if ({if_pc, if_instr, if_pc_plus4} !== 96'd0) begin n_err++; $display("FAIL rst_if: got %h %h %h want 0", if_pc, if_instr, if_pc_plus4); end
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", addr_err); end
    tick();
    rst = 0;
    // First cycle after release: IDLE, no request even though ack is high.
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL first_fetch: got req=%b addr=%h want 1 00400000", imem_req, imem_addr); end
  endtask

  // Continues from test_reset: FETCH at 00400000 with ack tied 1.
  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h0040_0000;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || if_valid !== 1'b0) begin n_err++; $display("FAIL seq_fetch%0d: got req=%b addr=%h vld=%b want 1 %h 0", i, imem_req, imem_addr, if_valid, exp_pc); end
      imem_rdata = 32'hA000_0000 + i;
      tick();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== (32'hA000_0000 + i) || if_pc_plus4 !== exp_pc + 32'd4 || imem_req !== 1'b0) begin n_err++; $display("FAIL seq_deliver%0d: got vld=%b pc=%h instr=%h p4=%h req=%b want 1 %h %h %h 0", i, if_valid, if_pc, if_instr, if_pc_plus4, imem_req, exp_pc, 32'hA000_0000 + i, exp_pc + 32'd4); end
      tick();
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ack = 1; imem_rdata = 32'hCAFE_BABE; stall = 1;
    tick();
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0000 || if_instr !== 32'hCAFE_BABE || imem_req !== 1'b0) begin n_err++; $display("FAIL stall_hold%0d: got vld=%b pc=%h instr=%h req=%b want 1 00400000 cafebabe 0", i, if_valid, if_pc, if_instr, imem_req); end
      if (i < 2) tick();
    end
    stall = 0;
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004 || if_valid !== 1'b0) begin n_err++; $display("FAIL stall_next: got req=%b addr=%h vld=%b want 1 00400004 0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_wait_redirect();
    do_reset();
    imem_ack = 0; redirect_valid = 1; redirect_pc = 32'h0040_0100;
    tick();
    redirect_valid = 0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL wait_hold1: got req=%b addr=%h want 1 00400000", imem_req, imem_addr); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL wait_hold2: got req=%b addr=%h want 1 00400000", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'hDEAD_DEAD;
    tick();
    imem_ack = 0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL wait_drop: got vld=%b want 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin n_err++; $display("FAIL wait_target: got req=%b addr=%h want 1 00400100", imem_req, imem_addr); end
    tick();
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h0040_0100) begin n_err++; $display("FAIL wait_idle_fetch: got vld=%b addr=%h want 0 00400100", if_valid, imem_addr); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    imem_ack = 1; imem_rdata = 32'hBAD0_BAD0; redirect_valid = 1; redirect_pc = 32'h0040_0200;
    tick();
    redirect_valid = 0;
    n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin n_err++; $display("FAIL coinc: got vld=%b req=%b addr=%h want 0 1 00400200", if_valid, imem_req, imem_addr); end
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 0;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0200 || if_instr !== 32'h1234_5678) begin n_err++; $display("FAIL coinc_deliver: got vld=%b pc=%h instr=%h want 1 00400200 12345678", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_misaligned();
    do_reset();
    imem_ack = 1; imem_rdata = 32'h0000_0001;
    tick();
    imem_ack = 0;
    n_cmp++; if (addr_err !== 1'b0 || if_valid !== 1'b1) begin n_err++; $display("FAIL mis_pre: got err=%b vld=%b want 0 1", addr_err, if_valid); end
    redirect_valid = 1; redirect_pc = 32'h0040_0203;
    tick();
    redirect_valid = 0;
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", addr_err); end
    n_cmp++; if (imem_addr !== 32'h0040_0200 || imem_req !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL mis_addr: got addr=%h req=%b vld=%b want 00400200 1 0", imem_addr, imem_req, if_valid); end
    tick();
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b want 0", addr_err); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ack = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_fetch: got %h want fffffffc", imem_addr); end
    imem_rdata = 32'h0BAD_F00D;
    tick();
    imem_ack = 0;
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0000_0000 || if_valid !== 1'b1) begin n_err++; $display("FAIL wrap_p4: got pc=%h p4=%h vld=%b want fffffffc 00000000 1", if_pc, if_pc_plus4, if_valid); end
    tick();
    n_cmp++; if (imem_addr !== 32'h0000_0000 || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_next: got addr=%h req=%b want 00000000 1", imem_addr, imem_req); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    imem_ack = 1; redirect_valid = 1; redirect_pc = 32'h0040_0300;
    tick();
    imem_ack = 0; redirect_pc = 32'h0040_0400;
    tick();
    redirect_valid = 0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0300) begin n_err++; $display("FAIL flush_pre: got req=%b addr=%h want 1 00400300", imem_req, imem_addr); end
    imem_ack = 1;
    #2 rst = 1;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL flush_rst: got req=%b addr=%h want 0 00400000", imem_req, imem_addr); end
    tick();
    rst = 0;
    imem_rdata = 32'h5151_5151;
    // Stale ack while IDLE must be ignored.
    tick();
    n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL flush_stale: got vld=%b req=%b addr=%h want 0 1 00400000", if_valid, imem_req, imem_addr); end
    tick();
    imem_ack = 0;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0000 || if_instr !== 32'h5151_5151) begin n_err++; $display("FAIL flush_recover: got vld=%b pc=%h instr=%h want 1 00400000 51515151", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_wait_redirect();
    test_redirect_ack();
    test_misaligned();
    test_wrap();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
